codec_intf: RTL and testbench

- Serial interface between the CS4272 audio CODEC and the equalizer datapath.
- Generates the CODEC clocks (MCLK, SCLK, LRCLK) and the CODEC reset (RSTn) from the 50 MHz system clock.
- Deserializes I2S data from the CODEC (SDout) into parallel 16-bit left/right samples with a valid strobe.
- Serializes the equalizer's processed left/right samples back onto SDin.
- Sits directly upstream of the filter bank (feeds it) and directly downstream of the band summer (consumes its output).

---
 rtl/codec_intf.sv | 140 ++++++++++++++
 tb/tb_codec_intf.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/codec_intf.sv
// rtl/codec_intf.sv - CS4272 I2S serial interface: clock/reset generation, ADC deserializer, DAC serializer
//
// Every CODEC timing signal is taken straight from one free-running 10-bit counter.
// SCLK is cnt[3]. LRCLK is cnt[9]. The slot index is cnt[8:4].
// Receive samples SDout one clk before SCLK rises.
// Transmit updates SDin one clk before SCLK falls.
module codec_intf #(
  parameter int DATA_W      = 16,
  parameter int RSTN_FRAMES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] lft_out,
  input  logic [DATA_W-1:0] rht_out,
  output logic [DATA_W-1:0] lft_in,
  output logic [DATA_W-1:0] rht_in,
  output logic              valid,
  output logic              MCLK,
  output logic              SCLK,
  output logic              LRCLK,
  output logic              RSTn,
  output logic              SDin,
  input  logic              SDout
);

  localparam logic [4:0]        LAST_SLOT = 5'(DATA_W);
  localparam logic [9:0]        RX_DONE   = {1'b1, LAST_SLOT, 4'h7};
  localparam int                WRAP_W    = (RSTN_FRAMES > 1) ? $clog2(RSTN_FRAMES) : 1;
  localparam logic [WRAP_W-1:0] WRAP_LAST = WRAP_W'(RSTN_FRAMES - 1);

  typedef enum logic {ST_HOLD, ST_RUN} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [9:0]        r_cnt;
  logic [WRAP_W-1:0] r_wraps;
  logic [DATA_W-1:0] r_rx_l;
  logic [DATA_W-1:0] r_rx_r;
  logic [DATA_W-1:0] r_lft_in;
  logic [DATA_W-1:0] r_rht_in;
  logic              r_valid;
  logic [DATA_W-1:0] r_tx_l;
  logic [DATA_W-1:0] r_tx_r;
  logic              r_sdin;

  logic [4:0]        w_slot;
  logic              w_sample;
  logic              w_drive;
  logic              w_frame_end;
  logic              w_rx_slot;
  logic              w_tx_slot;
  logic              w_tx_bit;

  assign w_slot      = r_cnt[8:4];
  assign w_sample    = (r_cnt[3:0] == 4'h7);
  assign w_drive     = (r_cnt[3:0] == 4'hF);
  assign w_frame_end = (r_cnt == 10'h3FF);
  assign w_rx_slot   = (w_slot != 5'd0) && (w_slot <= LAST_SLOT);
  assign w_tx_slot   = (w_slot < LAST_SLOT);
  assign w_tx_bit    = r_cnt[9] ? r_tx_r[DATA_W-1] : r_tx_l[DATA_W-1];

  assign MCLK   = r_cnt[1];
  assign SCLK   = r_cnt[3];
  assign LRCLK  = r_cnt[9];
  assign RSTn   = (r_state == ST_RUN);
  assign SDin   = r_sdin;
  assign valid  = r_valid;
  assign lft_in = r_lft_in;
  assign rht_in = r_rht_in;

  // Free-running frame counter; all CODEC clocks are bits of it, so they are glitch-free
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= r_cnt + 10'd1;
  end

  // Count frame wraps while the CODEC is still held in reset
  always_ff @(posedge clk) begin
    if (rst)                                                      r_wraps <= '0;
    else if (w_frame_end && r_state == ST_HOLD && r_wraps != WRAP_LAST) r_wraps <= r_wraps + 1'b1;
  end

  // CODEC reset state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_HOLD;
    else     r_state <= w_state_next;
  end

  // Release the CODEC on a frame boundary once enough wraps have passed, then stay released
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_HOLD: if (w_frame_end && r_wraps == WRAP_LAST) w_state_next = ST_RUN;
      ST_RUN:  w_state_next = ST_RUN;
      default: w_state_next = ST_HOLD;
    endcase
  end

  // Deserialize SDout MSB-first per channel; publish both words at the last right-channel bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_l   <= '0;
      r_rx_r   <= '0;
      r_lft_in <= '0;
      r_rht_in <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_sample && w_rx_slot) begin
        if (r_cnt[9]) r_rx_r <= {r_rx_r[DATA_W-2:0], SDout};
        else          r_rx_l <= {r_rx_l[DATA_W-2:0], SDout};
      end
      // The final right bit arrives on this same edge, so it is folded in directly
      if (r_cnt == RX_DONE && r_state == ST_RUN) begin
        r_lft_in <= r_rx_l;
        r_rht_in <= {r_rx_r[DATA_W-2:0], SDout};
        r_valid  <= 1'b1;
      end
    end
  end

  // Capture both channels together at frame end, then shift the active channel out onto SDin
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_l <= '0;
      r_tx_r <= '0;
      r_sdin <= 1'b0;
    end else begin
      if (w_frame_end) begin
        r_tx_l <= lft_out;
        r_tx_r <= rht_out;
      end else if (w_drive && w_tx_slot) begin
        if (r_cnt[9]) r_tx_r <= {r_tx_r[DATA_W-2:0], 1'b0};
        else          r_tx_l <= {r_tx_l[DATA_W-2:0], 1'b0};
      end
      if (w_drive) r_sdin <= (w_tx_slot && r_state == ST_RUN) ? w_tx_bit : 1'b0;
    end
  end

endmodule

// File: tb/tb_codec_intf.sv
// tb/tb_codec_intf.sv - directed self-checking bench for codec_intf
module tb_codec_intf;

  localparam int DW = 16;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic [DW-1:0] lft_out = '0;
  logic [DW-1:0] rht_out = '0;
  logic [DW-1:0] lft_in;
  logic [DW-1:0] rht_in;
  logic          valid;
  logic          MCLK;
  logic          SCLK;
  logic          LRCLK;
  logic          RSTn;
  logic          SDin;
  logic          SDout   = 1'b0;

  logic [9:0]    tb_cnt  = '0;
  logic [DW-1:0] src_l   = '0;
  logic [DW-1:0] src_r   = '0;
  int            n_cmp   = 0;
  int            n_bad   = 0;

  codec_intf #(.DATA_W(DW), .RSTN_FRAMES(1)) dut (
    .clk(clk), .rst(rst), .lft_out(lft_out), .rht_out(rht_out),
    .lft_in(lft_in), .rht_in(rht_in), .valid(valid),
    .MCLK(MCLK), .SCLK(SCLK), .LRCLK(LRCLK), .RSTn(RSTn),
    .SDin(SDin), .SDout(SDout)
  );

  always #10 clk = ~clk;

  // Reference frame position, independent of the DUT
  always @(posedge clk) begin
    if (rst) tb_cnt <= '0;
    else     tb_cnt <= tb_cnt + 10'd1;
  end

  // CODEC ADC model: I2S, MSB in slot 1, data changes around SCLK falling
  always @(negedge clk) begin
    int slot;
    slot = int'(tb_cnt[8:4]);
    if (slot >= 1 && slot <= DW) SDout = tb_cnt[9] ? src_r[DW-slot] : src_l[DW-slot];
    else                         SDout = 1'b0;
  end

  task automatic wait_cnt(input logic [9:0] v);
    int k;
    k = 0;
    while (tb_cnt !== v && k < 2100) begin
      @(negedge clk);
      k++;
    end
    if (tb_cnt !== v) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_cnt: reached cnt %h, wanted %h", tb_cnt, v);
    end
  endtask

  // CODEC DAC model: decode one frame of SDin at SCLK rises
  task automatic capture_frame(input bit chg, output logic [DW-1:0] l, output logic [DW-1:0] r,
                               output int zerr, output logic sd_0f, output logic sd_10);
    int slot;
    l = '0; r = '0; zerr = 0; sd_0f = 1'b0; sd_10 = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      if (chg && tb_cnt == 10'h100) lft_out = 16'h1111;
      if (tb_cnt == 10'h00F) sd_0f = SDin;
      if (tb_cnt == 10'h010) sd_10 = SDin;
      if (tb_cnt[3:0] == 4'h8) begin
        slot = int'(tb_cnt[8:4]);
        if (slot >= 1 && slot <= DW) begin
          if (tb_cnt[9]) r[DW-slot] = SDin;
          else           l[DW-slot] = SDin;
        end else if (SDin !== 1'b0) begin
          zerr++;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if ({MCLK, SCLK, LRCLK} !== 3'b000) begin n_bad++; $display("FAIL reset_clks: got %b, want 000", {MCLK, SCLK, LRCLK}); end
    n_cmp++; if (RSTn !== 1'b0) begin n_bad++; $display("FAIL reset_rstn: got %b, want 0", RSTn); end
    n_cmp++; if (SDin !== 1'b0) begin n_bad++; $display("FAIL reset_sdin: got %b, want 0", SDin); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b, want 0", valid); end
    n_cmp++; if (lft_in !== 16'h0) begin n_bad++; $display("FAIL reset_lft_in: got %h, want 0000", lft_in); end
    n_cmp++; if (rht_in !== 16'h0) begin n_bad++; $display("FAIL reset_rht_in: got %h, want 0000", rht_in); end
    rst = 1'b0;
  endtask

  task automatic test_clocks_rstn();
    int   e_clk, e_rstn, e_quiet, r_m, r_s, r_l, mis;
    logic pm, ps, pl;
    e_clk = 0; e_rstn = 0; e_quiet = 0; r_m = 0; r_s = 0; r_l = 0; mis = 0;
    pm = MCLK; ps = SCLK; pl = LRCLK;
    for (int i = 0; i < 4096; i++) begin
      if (i > 0) begin
        if (MCLK && !pm)  r_m++;
        if (SCLK && !ps)  r_s++;
        if (LRCLK && !pl) r_l++;
        if (LRCLK !== pl && !(ps && !SCLK)) mis++;
      end
      if (MCLK !== tb_cnt[1] || SCLK !== tb_cnt[3] || LRCLK !== tb_cnt[9]) e_clk++;
      if (RSTn !== (i >= 1024)) e_rstn++;
      if (i < 1024 && (valid !== 1'b0 || SDin !== 1'b0)) e_quiet++;
      pm = MCLK; ps = SCLK; pl = LRCLK;
      @(negedge clk);
    end
    n_cmp++; if (e_clk != 0) begin n_bad++; $display("FAIL clk_phase: %0d bad cycles, want 0", e_clk); end
    n_cmp++; if (r_m != 1024) begin n_bad++; $display("FAIL mclk_period: %0d rises, want 1024", r_m); end
    n_cmp++; if (r_s != 256) begin n_bad++; $display("FAIL sclk_period: %0d rises, want 256", r_s); end
    n_cmp++; if (r_l != 4) begin n_bad++; $display("FAIL lrclk_period: %0d rises, want 4", r_l); end
    n_cmp++; if (mis != 0) begin n_bad++; $display("FAIL lrclk_align: %0d misaligned edges, want 0", mis); end
    n_cmp++; if (e_rstn != 0) begin n_bad++; $display("FAIL rstn_timing: %0d bad cycles, want 0", e_rstn); end
    n_cmp++; if (e_quiet != 0) begin n_bad++; $display("FAIL first_frame_quiet: %0d bad cycles, want 0", e_quiet); end
  endtask

  task automatic test_receive();
    int            npulse;
    logic [9:0]    pcnt;
    logic [DW-1:0] pl, pr;
    npulse = 0; pcnt = '0; pl = '0; pr = '0;
    wait_cnt(10'h3FF);
    src_l = 16'h8001;
    src_r = 16'h7FFE;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        npulse++; pcnt = tb_cnt; pl = lft_in; pr = rht_in;
      end
    end
    n_cmp++; if (npulse != 1) begin n_bad++; $display("FAIL rx_strobes: %0d per frame, want 1", npulse); end
    n_cmp++; if (pcnt !== 10'h308) begin n_bad++; $display("FAIL rx_strobe_pos: got cnt %h, want 308", pcnt); end
    n_cmp++; if (pl !== 16'h8001) begin n_bad++; $display("FAIL rx_left: got %h, want 8001", pl); end
    n_cmp++; if (pr !== 16'h7FFE) begin n_bad++; $display("FAIL rx_right: got %h, want 7ffe", pr); end
    src_l = 16'h1234;
    src_r = 16'hABCD;
    wait_cnt(10'h307);
    n_cmp++; if (lft_in !== 16'h8001 || valid !== 1'b0) begin n_bad++; $display("FAIL rx_hold: got %h/%b, want 8001/0", lft_in, valid); end
    @(negedge clk);
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL rx_strobe2: got %b, want 1", valid); end
    n_cmp++; if (lft_in !== 16'h1234 || rht_in !== 16'hABCD) begin n_bad++; $display("FAIL rx_update: got %h/%h, want 1234/abcd", lft_in, rht_in); end
    @(negedge clk);
    n_cmp++; if (valid !== 1'b0 || lft_in !== 16'h1234) begin n_bad++; $display("FAIL rx_width: got %b/%h, want 0/1234", valid, lft_in); end
  endtask

  task automatic test_transmit();
    logic [DW-1:0] l, r;
    int            zerr;
    logic          s0f, s10;
    wait_cnt(10'h300);
    lft_out = 16'hA5C3;
    rht_out = 16'h3C5A;
    wait_cnt(10'h3FF);
    capture_frame(1'b1, l, r, zerr, s0f, s10);
    n_cmp++; if (l !== 16'hA5C3) begin n_bad++; $display("FAIL tx_left: got %h, want a5c3", l); end
    n_cmp++; if (r !== 16'h3C5A) begin n_bad++; $display("FAIL tx_right: got %h, want 3c5a", r); end
    n_cmp++; if (zerr != 0) begin n_bad++; $display("FAIL tx_idle_slots: %0d nonzero, want 0", zerr); end
    n_cmp++; if (s0f !== 1'b0 || s10 !== 1'b1) begin n_bad++; $display("FAIL tx_msb_latency: got %b%b at 00f/010, want 01", s0f, s10); end
    capture_frame(1'b0, l, r, zerr, s0f, s10);
    n_cmp++; if (l !== 16'h1111) begin n_bad++; $display("FAIL tx_next_left: got %h, want 1111", l); end
    n_cmp++; if (r !== 16'h3C5A) begin n_bad++; $display("FAIL tx_next_right: got %h, want 3c5a", r); end
    n_cmp++; if (zerr != 0) begin n_bad++; $display("FAIL tx_next_idle: %0d nonzero, want 0", zerr); end
  endtask

  task automatic test_mid_reset();
    int            first_v, rise;
    logic [DW-1:0] vl, vr;
    first_v = -1; rise = -1; vl = '0; vr = '0;
    wait_cnt(10'h205);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({MCLK, SCLK, LRCLK, SDin, RSTn, valid} !== 6'b0) begin n_bad++; $display("FAIL midrst_bits: got %b, want 000000", {MCLK, SCLK, LRCLK, SDin, RSTn, valid}); end
    n_cmp++; if (lft_in !== 16'h0 || rht_in !== 16'h0) begin n_bad++; $display("FAIL midrst_data: got %h/%h, want 0000/0000", lft_in, rht_in); end
    rst = 1'b0;
    for (int k = 1; k <= 16'h800; k++) begin
      @(negedge clk);
      if (RSTn === 1'b1 && rise < 0) rise = k;
      if (valid === 1'b1 && first_v < 0) begin first_v = k; vl = lft_in; vr = rht_in; end
    end
    n_cmp++; if (rise != 1024) begin n_bad++; $display("FAIL midrst_rstn: rose at %0d, want 1024", rise); end
    n_cmp++; if (first_v != 16'h708) begin n_bad++; $display("FAIL midrst_first_valid: at %0d, want 1800", first_v); end
    n_cmp++; if (vl !== 16'h1234 || vr !== 16'hABCD) begin n_bad++; $display("FAIL midrst_data_after: got %h/%h, want 1234/abcd", vl, vr); end
  endtask

  initial begin
    test_reset();
    test_clocks_rstn();
    test_receive();
    test_transmit();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
